// File: rtl/egr_pfs_dpb_ptr_tx.sv
`default_nettype none
// ============================================================================
// Module   : egr_pfs_dpb_ptr_tx
// Brief    : Buffers released segment pointers and returns them to the Dirty
//            Pointer Broker in request-driven bursts of 1..MAX_BURST beats.
// Revision : 1.0 - initial release
// ============================================================================
module egr_pfs_dpb_ptr_tx #(
  parameter int PTR_W     = 20,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             cclk,
  input  logic             rst,
  input  logic             pfs_rel_valid,
  input  logic [PTR_W-1:0] pfs_rel_ptr,
  output logic             pfs_rel_full,
  input  logic             dpb_req,
  input  logic [2:0]       dpb_req_num,
  output logic             dpb_req_rdy,
  output logic             dpb_rsp_valid,
  output logic [PTR_W-1:0] dpb_rsp_ptr,
  output logic             dpb_rsp_nack,
  output logic             dpb_rsp_last,
  output logic [CNT_W-1:0] ptr_cnt,
  output logic             ovf_err,
  output logic [7:0]       drop_cnt
);

  localparam int       c_addr_w = $clog2(DEPTH);
  localparam bit [2:0] c_max    = 3'(MAX_BURST);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [2:0]          r_remaining;
  logic [2:0]          w_rem_nxt;
  logic [2:0]          w_clamp;
  logic                r_ovf;
  logic [7:0]          r_drop;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic                w_rdy;
  logic                w_valid;
  logic                w_nack;
  logic                w_last;
  logic [PTR_W-1:0]    w_ptr;

  // Full/empty come from the registered count, so a same-cycle pop never
  // frees a slot for a push and a same-cycle push never feeds a beat.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = pfs_rel_valid & ~w_full;
  assign w_drop  = pfs_rel_valid & w_full;

  assign w_clamp = (dpb_req_num == 3'd0)  ? 3'd1  :
                   (dpb_req_num > c_max)  ? c_max : dpb_req_num;

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_pop       = 1'b0;
    w_rdy       = 1'b0;
    w_valid     = 1'b0;
    w_nack      = 1'b0;
    w_last      = 1'b0;
    w_ptr       = '0;
    case (r_state)
      ST_IDLE: begin
        w_rdy = ~rst;
        if (dpb_req && !rst) begin
          w_rem_nxt   = w_clamp;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!rst) begin
          w_valid = 1'b1;
          if (!w_empty) begin
            w_ptr     = r_mem[r_rd_ptr];
            w_pop     = 1'b1;
            w_rem_nxt = r_remaining - 3'd1;
            if (r_remaining == 3'd1) begin
              w_last      = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_nack      = 1'b1;
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_drop      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
    end
  end

  always_ff @(posedge cclk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= pfs_rel_ptr;
  end

  assign pfs_rel_full  = w_full;
  assign dpb_req_rdy   = w_rdy;
  assign dpb_rsp_valid = w_valid;
  assign dpb_rsp_ptr   = w_ptr;
  assign dpb_rsp_nack  = w_nack;
  assign dpb_rsp_last  = w_last;
  assign ptr_cnt       = r_count;
  assign ovf_err       = r_ovf;
  assign drop_cnt      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_egr_pfs_dpb_ptr_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_egr_pfs_dpb_ptr_tx
// Brief    : Directed scoreboard bench for the PFS-to-DPB pointer responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_egr_pfs_dpb_ptr_tx;

  localparam int PTR_W = 20;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             cclk = 1'b0;
  logic             rst;
  logic             pfs_rel_valid;
  logic [PTR_W-1:0] pfs_rel_ptr;
  logic             pfs_rel_full;
  logic             dpb_req;
  logic [2:0]       dpb_req_num;
  logic             dpb_req_rdy;
  logic             dpb_rsp_valid;
  logic [PTR_W-1:0] dpb_rsp_ptr;
  logic             dpb_rsp_nack;
  logic             dpb_rsp_last;
  logic [CNT_W-1:0] ptr_cnt;
  logic             ovf_err;
  logic [7:0]       drop_cnt;

  typedef struct packed {
    logic             nack;
    logic             last;
    logic [PTR_W-1:0] ptr;
  } beat_t;

  beat_t            sb [$];
  logic [PTR_W-1:0] mdl [$];
  int               mdl_drops = 0;
  int               n_cmp = 0;
  int               n_err = 0;
  beat_t            mon_exp;
  beat_t            mon_obs;

  egr_pfs_dpb_ptr_tx #(.PTR_W(PTR_W), .DEPTH(DEPTH), .MAX_BURST(4)) dut (
    .cclk          (cclk),
    .rst           (rst),
    .pfs_rel_valid (pfs_rel_valid),
    .pfs_rel_ptr   (pfs_rel_ptr),
    .pfs_rel_full  (pfs_rel_full),
    .dpb_req       (dpb_req),
    .dpb_req_num   (dpb_req_num),
    .dpb_req_rdy   (dpb_req_rdy),
    .dpb_rsp_valid (dpb_rsp_valid),
    .dpb_rsp_ptr   (dpb_rsp_ptr),
    .dpb_rsp_nack  (dpb_rsp_nack),
    .dpb_rsp_last  (dpb_rsp_last),
    .ptr_cnt       (ptr_cnt),
    .ovf_err       (ovf_err),
    .drop_cnt      (drop_cnt)
  );

  always #5 cclk = ~cclk;

  // Every response beat is checked against the head of the scoreboard.
  always @(negedge cclk) begin
    if (dpb_rsp_valid === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL beat_unexpected: observed ptr=0x%0h expected no beat", dpb_rsp_ptr);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        mon_obs = {dpb_rsp_nack, dpb_rsp_last, dpb_rsp_ptr};
        assert (mon_obs === mon_exp) else begin
          n_err++;
          $error("FAIL beat: observed nack=%0b last=%0b ptr=0x%0h expected nack=%0b last=%0b ptr=0x%0h",
                 mon_obs.nack, mon_obs.last, mon_obs.ptr, mon_exp.nack, mon_exp.last, mon_exp.ptr);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic mdl_push(input logic [PTR_W-1:0] p);
    if (mdl.size() < DEPTH) mdl.push_back(p);
    else if (mdl_drops < 255) mdl_drops++;
  endtask

  task automatic push(input logic [PTR_W-1:0] p);
    pfs_rel_valid = 1'b1;
    pfs_rel_ptr   = p;
    tick();
    pfs_rel_valid = 1'b0;
    pfs_rel_ptr   = '0;
    mdl_push(p);
  endtask

  // Issue one request; optionally push a pointer during the first beat cycle.
  task automatic req(input logic [2:0] n, input bit push_mid, input logic [PTR_W-1:0] pp);
    int    k;
    int    nb;
    int    lowc;
    beat_t b;
    k  = (n == 3'd0) ? 1 : ((n > 3'd4) ? 4 : int'(n));
    nb = 0;
    for (int i = 0; i < k; i++) begin
      nb++;
      if (mdl.size() > 0) begin
        b.nack = 1'b0;
        b.last = (i == k - 1);
        b.ptr  = mdl.pop_front();
        sb.push_back(b);
      end else begin
        b.nack = 1'b1;
        b.last = 1'b1;
        b.ptr  = '0;
        sb.push_back(b);
        break;
      end
    end
    dpb_req     = 1'b1;
    dpb_req_num = n;
    tick();
    dpb_req     = 1'b0;
    dpb_req_num = '0;
    lowc = 0;
    while (dpb_req_rdy !== 1'b1 && lowc < 12) begin
      lowc++;
      if (push_mid && lowc == 1) begin
        pfs_rel_valid = 1'b1;
        pfs_rel_ptr   = pp;
      end
      tick();
      if (push_mid && lowc == 1) begin
        pfs_rel_valid = 1'b0;
        pfs_rel_ptr   = '0;
        mdl_push(pp);
      end
    end
    chk("rdy_low_cycles", 32'(lowc), 32'(nb));
  endtask

  initial begin
    beat_t b;
    rst           = 1'b1;
    pfs_rel_valid = 1'b0;
    pfs_rel_ptr   = '0;
    dpb_req       = 1'b0;
    dpb_req_num   = '0;
    tick();
    tick();
    chk("rdy_in_reset", 32'(dpb_req_rdy), 32'd0);
    chk("valid_in_reset", 32'(dpb_rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rdy_after_reset", 32'(dpb_req_rdy), 32'd1);
    chk("cnt_reset", 32'(ptr_cnt), 32'd0);
    chk("full_reset", 32'(pfs_rel_full), 32'd0);
    chk("ovf_reset", 32'(ovf_err), 32'd0);
    chk("drop_reset", 32'(drop_cnt), 32'd0);

    // Basic two-beat burst
    push(20'h00011);
    push(20'h00022);
    push(20'h00033);
    chk("cnt_3", 32'(ptr_cnt), 32'd3);
    req(3'd2, 1'b0, '0);
    chk("cnt_after_req2", 32'(ptr_cnt), 32'd1);
    req(3'd1, 1'b0, '0);
    chk("cnt_drained", 32'(ptr_cnt), 32'd0);

    // Burst runs dry: one pointer then a nack
    push(20'h00AAA);
    req(3'd4, 1'b0, '0);
    chk("rdy_after_nack", 32'(dpb_req_rdy), 32'd1);
    chk("cnt_after_nack", 32'(ptr_cnt), 32'd0);

    // Clamping of request size
    push(20'h00123);
    req(3'd0, 1'b0, '0);
    for (int i = 0; i < 16; i++) push(20'h00100 + 20'(i));
    chk("full_16", 32'(pfs_rel_full), 32'd1);
    req(3'd7, 1'b0, '0);
    chk("cnt_after_req7", 32'(ptr_cnt), 32'd12);
    for (int i = 0; i < 3; i++) req(3'd4, 1'b0, '0);
    chk("cnt_empty_again", 32'(ptr_cnt), 32'd0);

    // Overflow with wrapped pointers, then in-order drain
    for (int i = 0; i < 19; i++) push(20'h00200 + 20'(i));
    chk("full_ovf", 32'(pfs_rel_full), 32'd1);
    chk("cnt_ovf", 32'(ptr_cnt), 32'd16);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    chk("drop_3", 32'(drop_cnt), 32'(mdl_drops));
    for (int i = 0; i < 4; i++) req(3'd4, 1'b0, '0);
    chk("cnt_after_drain", 32'(ptr_cnt), 32'd0);
    chk("full_after_drain", 32'(pfs_rel_full), 32'd0);
    chk("ovf_sticky", 32'(ovf_err), 32'd1);

    // Push into an empty FIFO during a beat is not visible to that beat
    req(3'd1, 1'b1, 20'h55555);
    chk("cnt_after_same_cycle_push", 32'(ptr_cnt), 32'd1);
    req(3'd1, 1'b0, '0);
    chk("cnt_zero_final", 32'(ptr_cnt), 32'd0);

    // Reset during the second beat of a four-beat burst
    for (int i = 0; i < 4; i++) push(20'h00300 + 20'(i));
    b.nack = 1'b0;
    b.last = 1'b0;
    b.ptr  = mdl.pop_front();
    sb.push_back(b);
    dpb_req     = 1'b1;
    dpb_req_num = 3'd4;
    tick();
    dpb_req     = 1'b0;
    dpb_req_num = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_valid", 32'(dpb_rsp_valid), 32'd0);
    chk("rst_cnt", 32'(ptr_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_rdy_low", 32'(dpb_req_rdy), 32'd0);
    rst = 1'b0;
    mdl.delete();
    mdl_drops = 0;
    #1;
    chk("rdy_after_rst", 32'(dpb_req_rdy), 32'd1);
    tick();
    tick();
    chk("no_beat_after_rst", 32'(dpb_rsp_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
